// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative multiply/divide unit holding the architectural HI/LO
// registers of the single-cycle MIPS core. It sits in the execute stage beside
// the ALU.
//
// A MULT/MULTU/DIV/DIVU instruction issues in one cycle and retires at once.
// The unit then runs WIDTH background iterations: shift-add for multiply and
// restoring shift-subtract for divide. The core is stalled only when a later
// instruction touches HI/LO, or tries to start another operation, while the
// unit is still busy.
//
// Ports:
//   CLK      system clock; all state changes on the rising edge
//   RST      asynchronous reset, active low
//   Ins      current instruction; the core holds it stable while Stall=1
//   Rdata1   rs operand (multiplicand / dividend / MTHI-MTLO source)
//   Rdata2   rt operand (multiplier / divisor)
//   HiLoOut  HI for MFHI, LO for MFLO, otherwise 0 (combinational)
//   Stall    freeze PC and register write this cycle (combinational)
//   Busy     an iteration sequence is in progress
module hilo_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      Ins,
  input  logic [WIDTH-1:0] Rdata1,
  input  logic [WIDTH-1:0] Rdata2,
  output logic [WIDTH-1:0] HiLoOut,
  output logic             Stall,
  output logic             Busy
);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t r_state;
  state_t w_state_next;

  // Architectural registers and iteration datapath.
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_acc;   // partial-product high half / partial remainder
  logic [WIDTH-1:0] r_q;     // multiplier shifting out / dividend -> quotient
  logic [WIDTH-1:0] r_m;     // multiplicand / divisor magnitude
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic             r_neg_q;  // negate product / quotient at the end
  logic             r_neg_r;  // negate remainder (takes the dividend's sign)
  logic             r_div0;   // divisor was zero

  // ------------------------------------------------------------------
  // Instruction decode
  // ------------------------------------------------------------------
  logic       w_op_zero;
  logic [5:0] w_funct;
  logic       w_is_mfhi, w_is_mthi, w_is_mflo, w_is_mtlo;
  logic       w_is_muldiv;
  logic       w_hilo_ins;
  logic       w_unused;

  assign w_op_zero   = (Ins[31:26] == 6'd0);
  assign w_funct     = Ins[5:0];
  assign w_is_mfhi   = w_op_zero && (w_funct == 6'h10);
  assign w_is_mthi   = w_op_zero && (w_funct == 6'h11);
  assign w_is_mflo   = w_op_zero && (w_funct == 6'h12);
  assign w_is_mtlo   = w_op_zero && (w_funct == 6'h13);
  // Funct values 0x18..0x1B are MULT, MULTU, DIV, DIVU.
  assign w_is_muldiv = w_op_zero && (w_funct[5:2] == 4'b0110);
  assign w_hilo_ins  = w_is_mfhi || w_is_mthi || w_is_mflo || w_is_mtlo || w_is_muldiv;
  // The register fields between the opcode and funct are not used here.
  assign w_unused    = &{1'b0, Ins[25:6]};

  // ------------------------------------------------------------------
  // Operand conditioning at issue. Bit 0 of funct clear means signed,
  // and bit 1 set means divide.
  // ------------------------------------------------------------------
  logic             w_signed;
  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;

  assign w_signed = ~w_funct[0];
  assign w_a_neg  = w_signed && Rdata1[WIDTH-1];
  assign w_b_neg  = w_signed && Rdata2[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -Rdata1 : Rdata1;
  assign w_b_mag  = w_b_neg ? -Rdata2 : Rdata2;

  // ------------------------------------------------------------------
  // One iteration step
  // ------------------------------------------------------------------
  logic [WIDTH:0]   w_msum;
  logic [WIDTH:0]   w_rsh;
  logic [WIDTH:0]   w_trial;
  logic             w_div_ok;
  logic [WIDTH-1:0] w_acc_nx;
  logic [WIDTH-1:0] w_q_nx;

  // Multiply: conditionally add the multiplicand, then shift {carry,acc,q} right.
  assign w_msum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);
  // Divide: shift {acc,q} left by one and try to subtract the divisor. One extra
  // bit holds the shifted remainder; its MSB after the subtract is the borrow.
  assign w_rsh    = {r_acc, r_q[WIDTH-1]};
  assign w_trial  = w_rsh - {1'b0, r_m};
  assign w_div_ok = ~w_trial[WIDTH];

  always_comb begin
    w_acc_nx = w_msum[WIDTH:1];
    w_q_nx   = {w_msum[0], r_q[WIDTH-1:1]};
    if (r_is_div) begin
      w_acc_nx = w_div_ok ? w_trial[WIDTH-1:0] : w_rsh[WIDTH-1:0];
      w_q_nx   = {r_q[WIDTH-2:0], w_div_ok};
    end
  end

  // ------------------------------------------------------------------
  // Sign fix-up applied on the final step
  // ------------------------------------------------------------------
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic               w_last;

  assign w_prod     = {w_acc_nx, w_q_nx};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
  // With a zero divisor the remainder path ends holding |dividend|. Restoring
  // the dividend's sign gives back the original dividend for HI. The
  // quotient is forced to all ones.
  assign w_quo_fix  = r_div0 ? '1 : (r_neg_q ? -w_q_nx : w_q_nx);
  assign w_rem_fix  = r_neg_r ? -w_acc_nx : w_acc_nx;
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_is_muldiv) w_state_next = ST_BUSY;
      ST_BUSY: if (w_last)      w_state_next = ST_IDLE;
      default:                  w_state_next = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Datapath and HI/LO
  // ------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_m      <= '0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Stall is always low in IDLE, so every HI/LO instruction takes effect.
          if (w_is_muldiv) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_is_div <= w_funct[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_div0   <= (Rdata2 == '0);
            r_q      <= w_funct[1] ? w_a_mag : w_b_mag;
            r_m      <= w_funct[1] ? w_b_mag : w_a_mag;
          end else if (w_is_mthi) begin
            r_hi <= Rdata1;
          end else if (w_is_mtlo) begin
            r_lo <= Rdata1;
          end
        end
        ST_BUSY: begin
          r_acc <= w_acc_nx;
          r_q   <= w_q_nx;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            if (r_is_div) begin
              r_lo <= w_quo_fix;
              r_hi <= w_rem_fix;
            end else begin
              {r_hi, r_lo} <= w_prod_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign Busy  = (r_state == ST_BUSY);
  assign Stall = Busy && w_hilo_ins;

  always_comb begin
    HiLoOut = '0;
    if (w_is_mfhi)      HiLoOut = r_hi;
    else if (w_is_mflo) HiLoOut = r_lo;
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv. The stimulus tasks push each expected
// MFHI/MFLO result into a queue. A monitor on the falling clock edge pops
// and compares whenever the DUT presents a read, meaning an MF instruction
// with Stall low. Stall and Busy cycle counts are checked directly by the
// stimulus tasks.
module tb_hilo_muldiv;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] Ins;
  logic [31:0] Rdata1;
  logic [31:0] Rdata2;
  logic [31:0] HiLoOut;
  logic        Stall;
  logic        Busy;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [31:0] I_LW   = 32'h8C000000;  // lw: opcode 0x23
  localparam logic [31:0] I_ADD  = 32'h00851020;  // add $2,$4,$5

  hilo_muldiv #(.WIDTH(32), .CNT_W(6)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .Ins     (Ins),
    .Rdata1  (Rdata1),
    .Rdata2  (Rdata2),
    .HiLoOut (HiLoOut),
    .Stall   (Stall),
    .Busy    (Busy)
  );

  always #5 CLK = ~CLK;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [31:0] mon_exp;
  string       mon_name;

  function automatic logic [31:0] rtype(input logic [5:0] f);
    return {26'd0, f};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Scoreboard monitor
  always @(negedge CLK) begin
    if (RST === 1'b1 && Ins[31:26] == 6'd0 &&
        (Ins[5:0] == F_MFHI || Ins[5:0] == F_MFLO) && Stall === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_read: got=%h expected=<no pending read>", HiLoOut);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        check(mon_name, HiLoOut, mon_exp);
      end
    end
  end

  // Present an instruction and hold it until it is accepted (Stall low at the
  // edge). Returns the number of stalled cycles.
  task automatic hold(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                      output int stalls);
    bit done;
    Ins    = ins;
    Rdata1 = a;
    Rdata2 = b;
    stalls = 0;
    done   = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge CLK);
      if (!Stall) done = 1'b1;
      else        stalls++;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL hold_timeout: got=stall for %0d cycles expected=release", stalls);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input string nm, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, input int exp_stalls);
    int s;
    hold(rtype(f), a, b, s);
    check({nm, "_stalls"}, s, exp_stalls);
  endtask

  task automatic mf(input string nm, input logic [5:0] f, input logic [31:0] exp,
                    input int exp_stalls);
    int s;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    hold(rtype(f), 32'h0, 32'h0, s);
    check({nm, "_stalls"}, s, exp_stalls);
  endtask

  // Feed unrelated instructions until Busy drops; count busy and stall cycles.
  task automatic run_busy(output int busy_cyc, output int stall_cyc);
    bit done;
    busy_cyc  = 0;
    stall_cyc = 0;
    done      = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      Ins    = i[0] ? I_ADD : I_LW;
      Rdata1 = $urandom;
      Rdata2 = $urandom;
      @(negedge CLK);
      if (!Busy) begin
        done = 1'b1;
      end else begin
        busy_cyc++;
        if (Stall) stall_cyc++;
      end
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, sc;
    RST    = 1'b1;
    Ins    = rtype(F_MFLO);
    Rdata1 = 32'h0;
    Rdata2 = 32'h0;
    #2 RST = 1'b0;
    #3;
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_stall", {31'd0, Stall}, 32'd0);
    check("reset_mflo", HiLoOut, 32'h0);
    Ins = rtype(F_MFHI);
    #1;
    check("reset_mfhi", HiLoOut, 32'h0);
    Ins = I_LW;
    #16 RST = 1'b1;
    @(posedge CLK);
    #1;
    mf("rd_hi0", F_MFHI, 32'h0, 0);
    mf("rd_lo0", F_MFLO, 32'h0, 0);

    // MULT -3 * 7 = -21
    issue("mult", F_MULT, 32'hFFFFFFFD, 32'd7, 0);
    mf("mult_lo", F_MFLO, 32'hFFFFFFEB, 32);
    mf("mult_hi", F_MFHI, 32'hFFFFFFFF, 0);

    // MULTU with unrelated instructions during BUSY
    issue("multu", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_busy(bc, sc);
    check("multu_busy_cycles", bc, 32);
    check("multu_unrelated_stalls", sc, 0);
    mf("multu_hi", F_MFHI, 32'hFFFFFFFE, 0);
    mf("multu_lo", F_MFLO, 32'h00000001, 0);

    // Signed and unsigned divides
    issue("div", F_DIV, 32'hFFFFFFF9, 32'd2, 0);
    mf("div_lo", F_MFLO, 32'hFFFFFFFD, 32);
    mf("div_hi", F_MFHI, 32'hFFFFFFFF, 0);
    issue("divu", F_DIVU, 32'd7, 32'd2, 0);
    mf("divu_lo", F_MFLO, 32'd3, 32);
    mf("divu_hi", F_MFHI, 32'd1, 0);
    issue("div_ovf", F_DIV, 32'h80000000, 32'hFFFFFFFF, 0);
    mf("div_ovf_lo", F_MFLO, 32'h80000000, 32);
    mf("div_ovf_hi", F_MFHI, 32'h0, 0);

    // Divide by zero
    issue("divu0", F_DIVU, 32'h00001234, 32'h0, 0);
    run_busy(bc, sc);
    check("divu0_busy_cycles", bc, 32);
    mf("divu0_lo", F_MFLO, 32'hFFFFFFFF, 0);
    mf("divu0_hi", F_MFHI, 32'h00001234, 0);
    issue("div0_neg", F_DIV, 32'hFFFFFF00, 32'h0, 0);
    mf("div0_neg_lo", F_MFLO, 32'hFFFFFFFF, 32);
    mf("div0_neg_hi", F_MFHI, 32'hFFFFFF00, 0);

    // MTHI / MTLO
    issue("mthi", F_MTHI, 32'hA5A5A5A5, 32'h0, 0);
    issue("mtlo", F_MTLO, 32'h5A5A5A5A, 32'h0, 0);
    mf("mt_hi", F_MFHI, 32'hA5A5A5A5, 0);
    mf("mt_lo", F_MFLO, 32'h5A5A5A5A, 0);

    // A second MULT issued while busy waits for the first to finish
    issue("mult_a", F_MULT, 32'd5, 32'd6, 0);
    issue("mult_b", F_MULT, 32'hFFFFFFFE, 32'd3, 32);
    mf("mult_b_lo", F_MFLO, 32'hFFFFFFFA, 32);
    mf("mult_b_hi", F_MFHI, 32'hFFFFFFFF, 0);

    // Asynchronous reset in the middle of a MULT
    issue("mult_rst", F_MULT, 32'd5, 32'd6, 0);
    Ins = I_LW;
    repeat (9) @(posedge CLK);
    #1;
    Ins = rtype(F_MFLO);
    exp_q.push_back(32'h0);
    name_q.push_back("rst_mflo_read");
    #1;
    check("pre_rst_stall", {31'd0, Stall}, 32'd1);
    RST = 1'b0;
    #1;
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_stall", {31'd0, Stall}, 32'd0);
    check("rst_async_lo", HiLoOut, 32'h0);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    mf("rst_hi", F_MFHI, 32'h0, 0);

    Ins = I_LW;
    @(negedge CLK);
    check("pending_reads", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS core.
- Sits in the execute stage beside the ALU, directly upstream of data memory/write-back. Its HiLoOut is muxed into the Result bus that data memory consumes for MFHI/MFLO.
- Issues MULT/MULTU/DIV/DIVU in one cycle, then computes over a fixed 32 cycles in the background.
- Raises Stall only when a later instruction needs HI/LO, or needs the unit, before the result is ready.

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-low reset.
- Ins  input  32  current instruction; held stable by the core while Stall=1.
- Rdata1  input  32  rs operand (multiplicand / dividend / MTHI-MTLO source).
- Rdata2  input  32  rt operand (multiplier / divisor).
- HiLoOut  output  32  HI for MFHI, LO for MFLO, else 0; combinational.
- Stall  output  1  freeze PC and register write this cycle; combinational.
- Busy  output  1  iteration in progress (state==BUSY).

Behaviour:
- Decode rule: a HI/LO instruction has Opcode=0 (Ins[31:26]) and one of these Funct values (Ins[5:0]).
  - MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13.
  - MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B.
  - All other instructions are ignored.
- Reset (RST=0, async): HI=0, LO=0, state=IDLE, counter=0, internal operand regs=0. Outputs: Busy=0, Stall=0, HiLoOut=0 (MFHI/MFLO read 0).
- States: IDLE, BUSY.
- IDLE -> BUSY on an edge where Ins is MULT/MULTU/DIV/DIVU and Stall=0.
  - Latch the operands: magnitudes for signed ops, plus result-sign flags.
  - Clear counter; the issuing instruction retires that cycle with no stall.
- BUSY: each edge performs one step and increments the counter.
  - Multiply: shift-add step.
  - Divide: restoring shift-subtract step.
- BUSY -> IDLE on the edge where counter==WIDTH-1.
  - The final step, sign fix-up and HI/LO write all happen on that edge.
  - Net latency: an op issued at edge E0 writes HI/LO at edge E32, readable in the cycle after E32.
- Stall=1 iff state==BUSY and Ins is any HI/LO instruction (MF*, MT*, or a new mult/div). Otherwise Stall=0.
  - Non-HI/LO instructions never stall during BUSY.
- MTHI/MTLO with Stall=0: write Rdata1 into HI/LO at the edge; the other register is unchanged.
- MFHI/MFLO with Stall=0 read the current register. No forwarding of same-edge writes.
- MULT/MULTU: {HI,LO} = full 64-bit product (signed or unsigned).
- DIV (signed): LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
- DIVU (unsigned): LO = quotient, HI = remainder.
- Divide by zero (DIV or DIVU): LO=0xFFFFFFFF, HI=dividend. Still takes the full 32 cycles.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Reset mid-operation: aborts immediately; HI/LO cleared, no partial result is written.
- Ins changing during BUSY has no effect on the in-flight computation (operands already latched).

Test Plan:
- MULT Rdata1=0xFFFFFFFD (-3), Rdata2=7; then MFLO next cycle -> Stall=1 for exactly 32 cycles; then HiLoOut=0xFFFFFFEB; MFHI -> 0xFFFFFFFF.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> after 32 cycles HI=0xFFFFFFFE, LO=0x00000001. Unrelated Ins during BUSY -> Stall=0 throughout.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 0x1234/0 -> LO=0xFFFFFFFF, HI=0x00001234, Busy high 32 cycles.
- MTHI 0xA5A5A5A5, MTLO 0x5A5A5A5A, then MFHI/MFLO -> same values, zero stall. A second MULT issued while BUSY -> Stall=1 until the first completes, then it issues.
- Pulse RST low at cycle 10 of a MULT -> Busy=0, Stall=0, HI=LO=0 asynchronously; the next MFLO reads 0.
